conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Streaming producer for the 5x5 convolution datapath (multiplier + adder tree).
- Accepts a raster-order stream of Q8.8 pixels, one per handshake, and buffers KERNEL_SIZE-1 lines.
- Emits each complete 5x5 window as one flattened bus, in the exact layout of the multiplier's pixel_data input.
- Valid-mode convolution (no padding), with ready/valid flow control on both sides.

Parameters:
- KERNEL_SIZE, 5, window edge length; fixed at 5 for this revision.
- DATA_WIDTH, 16, pixel width; signed Q8.8.
- IMG_WIDTH, 32, pixels per image line; legal range is KERNEL_SIZE or greater.
- IMG_HEIGHT, 32, lines per frame; legal range is KERNEL_SIZE or greater.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_pixel  in  DATA_WIDTH  pixel, raster order, row 0 col 0 first.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  block can accept a pixel this cycle.
- out_window  out  (KERNEL_SIZE**2)*DATA_WIDTH  flattened window; element i at [i*DATA_WIDTH +: DATA_WIDTH], i = r*KERNEL_SIZE + c.
- out_valid  out  1  out_window holds a new window.
- out_ready  in  1  downstream accepts the window this cycle.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset (rst=1 at a clock edge): col_cnt=0, row_cnt=0, out_valid=0, out_window=0, frame_done=0. Line buffer contents are don't-care; they are never exposed before being refilled.
- Reset mid-frame discards the partial frame. The next accepted pixel is (row 0, col 0).
- Input accept: accept = in_valid && in_ready. Define in_ready = !out_valid || out_ready (combinational).
- On each accept, the pixel shifts into the window column pipeline and into 4 line buffers of depth IMG_WIDTH (cascaded).
- On each accept, col_cnt increments. At IMG_WIDTH-1 it wraps to 0 and row_cnt increments. At the last pixel (row IMG_HEIGHT-1, col IMG_WIDTH-1), both wrap to 0 and frame_done pulses on the next cycle.
- Window definition: for an accepted pixel at (y, x) with y>=4 and x>=4, the window element (r, c) = pixel(y-4+r, x-4+c). Element 0 is the top-left, element 24 is the pixel just accepted.
- Output timing: out_window and out_valid are registered and update on the edge after that accept. Latency is 1 cycle.
- Accepts with x<4 or y<4 update the buffers only; they produce no window. Windows never straddle a line wrap.
- out_valid clears on out_ready && !(new window this cycle). If out_ready and a new window arrive in the same cycle, out_valid stays 1 and out_window is replaced.
- While out_valid && !out_ready, in_ready=0 and out_window stays stable (AXI-style hold).
- Windows per frame: (IMG_WIDTH-4)*(IMG_HEIGHT-4), in raster order of their bottom-right pixel.
- Arithmetic: none. Data passes bit-exact with no sign extension or rounding.
- Counters are $clog2 sized. No back-to-back frame bubble: row 0 of the next frame may be accepted the cycle after the last pixel.

Decomposition:
- Shared package/header conv_pkg: KERNEL_SIZE, DATA_WIDTH, the Q8.8 fractional-bit constant (8), and the pixel element type. Shared with the multiplier and adder tree so the window layout has one definition.
- Sub-module line_buffer: a DEPTH x DATA_WIDTH shift FIFO with a shift enable, giving a tap of the pixel exactly DEPTH accepts ago. Instantiate it 4 times.
- The top level holds the counters, the 5x5 register array, the output register and the handshake.

Test Plan:
- Basic fill (IMG_WIDTH=8, IMG_HEIGHT=8, pixel = y*8+x raw, in_valid=1, out_ready=1):
  - First out_valid comes the cycle after pixel 36 is accepted.
  - That window has element 0 = 0, element 12 = 18, element 24 = 36.
  - Exactly 16 windows per frame; the last has element 24 = 63.
  - frame_done pulses once.
- Line wrap: same stream. No window follows accepts of x=0..3; the window after pixel 44 (y=5, x=4) has element 0 = 8.
- Backpressure: hold out_ready=0 for 5 cycles after the first window.
  - in_ready=0 and out_window stay constant during the hold.
  - After release, the window sequence matches the unstalled run exactly.
  - No pixel is lost or duplicated.
- Input bubbles: toggle in_valid randomly. The window sequence is identical to the continuous run, and windows appear only after accepts.
- Reset mid-frame: assert rst after 20 pixels.
  - Next cycle: out_valid=0 and counters are 0.
  - Restreaming a full frame gives the same 16 windows as the basic fill.
- Integration: all pixels 0x0200, weights 0x0100, bias 0, chained to the multiplier + adder tree. Every window gives final_result = 0x3200 (50.0 in Q8.8).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and pixel type for the 5x5 convolution datapath.
// The window layout (element i = r*KERNEL_SIZE + c) is defined once here.
package conv_pkg;
    localparam int unsigned KERNEL_SIZE  = 5;
    localparam int unsigned DATA_WIDTH   = 16;
    localparam int unsigned FRAC_BITS    = 8;
    localparam int unsigned WINDOW_ELEMS = KERNEL_SIZE * KERNEL_SIZE;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// Shift FIFO of DEPTH pixels; tap is the pixel accepted exactly DEPTH shifts ago.
module line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic   clk,
    input  logic   shift_en,
    input  pixel_t din,
    output pixel_t tap
);

    pixel_t mem [DEPTH];

    // Contents are never exposed before refill, so no reset is needed.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tap = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream to 5x5 window generator (valid-mode, no padding) with
// ready/valid handshake on both sides and a registered flattened window output.
module conv_window_gen #(
    parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int unsigned DATA_WIDTH  = conv_pkg::DATA_WIDTH,
    parameter int unsigned IMG_WIDTH   = 32,
    parameter int unsigned IMG_HEIGHT  = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DATA_WIDTH-1:0]                       in_pixel,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_window,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        frame_done
);

    localparam int unsigned NUM_LB = KERNEL_SIZE - 1;
    localparam int unsigned COL_W  = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W  = $clog2(IMG_HEIGHT);
    localparam int unsigned WIN_W  = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

    logic [COL_W-1:0]      col_cnt;
    logic [ROW_W-1:0]      row_cnt;
    logic                  accept;
    logic                  last_col;
    logic                  last_row;
    logic                  win_ok;
    logic [DATA_WIDTH-1:0] lb_tap   [NUM_LB];
    logic [DATA_WIDTH-1:0] col_vec  [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] hist     [KERNEL_SIZE][KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] hist_nxt [KERNEL_SIZE][KERNEL_SIZE-1];
    logic [WIN_W-1:0]      win_flat;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign last_col = (col_cnt == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row_cnt == ROW_W'(IMG_HEIGHT - 1));
    assign win_ok   = (col_cnt >= COL_W'(KERNEL_SIZE - 1)) &&
                      (row_cnt >= ROW_W'(KERNEL_SIZE - 1));

    // Cascaded line buffers: tap i holds the pixel i+1 lines above the input.
    for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
        if (i == 0) begin : g_head
            line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
                .clk      (clk),
                .shift_en (accept),
                .din      (in_pixel),
                .tap      (lb_tap[i])
            );
        end else begin : g_tail
            line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
                .clk      (clk),
                .shift_en (accept),
                .din      (lb_tap[i-1]),
                .tap      (lb_tap[i])
            );
        end
    end

    // Newest window column: row 0 is the oldest line, row K-1 the incoming pixel.
    always_comb begin
        col_vec[KERNEL_SIZE-1] = in_pixel;
        for (int i = 0; i < int'(NUM_LB); i++) begin
            col_vec[int'(NUM_LB) - 1 - i] = lb_tap[i];
        end
    end

    // Window as it stands after this accept: K-1 history columns plus the new column.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
            for (int c = 0; c < int'(KERNEL_SIZE) - 2; c++) begin
                hist_nxt[r][c] = hist[r][c+1];
            end
            hist_nxt[r][KERNEL_SIZE-2] = col_vec[r];
            for (int c = 0; c < int'(KERNEL_SIZE) - 1; c++) begin
                win_flat[(r*int'(KERNEL_SIZE) + c)*int'(DATA_WIDTH) +: DATA_WIDTH] = hist[r][c];
            end
            win_flat[(r*int'(KERNEL_SIZE) + int'(KERNEL_SIZE) - 1)*int'(DATA_WIDTH) +: DATA_WIDTH] =
                col_vec[r];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hist <= hist_nxt;
        end
    end

    // Raster counters, output register and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && last_col && last_row;
            if (accept) begin
                col_cnt <= last_col ? '0 : col_cnt + COL_W'(1);
                if (last_col) begin
                    row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
                end
            end
            if (accept && win_ok) begin
                out_valid  <= 1'b1;
                out_window <= win_flat;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
